wb_write_port: RTL

//  Write-side driver of the 32x64 register file (X31 = XZR, reads 0). Buffers writeback results from
//  the MEM/WB boundary in a small FIFO; retires one write per cycle on RegWrite/WriteRegister/WriteData.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_fifo.sv | 78 +++++++
 rtl/wb_write_port.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the register-file write port: the writeback entry and the zero-register index.
package wb_pkg;

    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_entry_t;

    // True when a live entry targets the queried register; XZR never reports a hit.
    function automatic logic wb_hit(input logic [4:0] rs, input logic vld, input wb_entry_t e);
        return vld && (e.rd == rs) && (rs != XZR_IDX);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Purpose: DEPTH-entry writeback FIFO exposing every slot and its valid bit for hazard compares.
// Latency: push visible at head the cycle after the push edge; pop frees the slot on the same edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  wb_entry_t                   push_dat,
    input  logic                        pop,
    output wb_entry_t                   head_dat,
    output logic                        full,
    output logic                        empty,
    output logic [CW-1:0]               count,
    output logic [PW-1:0]               head_ptr,
    output wb_entry_t [DEPTH-1:0]       entries,
    output logic [DEPTH-1:0]            entry_vld
);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        entry_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_vld[i] = ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q);
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign entries  = mem_q;
    assign head_ptr = rd_ptr_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));

endmodule

// File: rtl/wb_write_port.sv
// Purpose: register-file write driver; queues writebacks, retires one per cycle, flags pending hazards (WB_BYPASS_EN adds forwarding).
// Latency: accept into an empty queue with hold low -> RegWrite high the next cycle.
// Backpressure: in_ready low while the queue holds DEPTH entries, even if it pops that cycle.
module wb_write_port
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_regwrite,
    input  logic [4:0]  in_rd,
    input  logic [63:0] in_data,
    input  logic        hold,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        fwd1_valid,
    output logic [63:0] fwd1_data,
    output logic        fwd2_valid,
    output logic [63:0] fwd2_data,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [63:0] WriteData
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t             in_ent;
    wb_entry_t             head_dat;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      entry_vld;
    logic [CW-1:0]         fifo_count;
    logic [PW-1:0]         head_ptr;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic accept_vld;
    logic keep_vld;
    logic pop_vld;
    logic direct_vld;
    logic push_vld;

    wb_entry_t out_q, out_d;
    logic      out_vld_q, out_vld_d;

    assign in_ent     = '{rd: in_rd, data: in_data};
    assign in_ready   = (fifo_count < CW'(DEPTH));
    assign accept_vld = in_valid & in_ready;
    assign keep_vld   = accept_vld & in_regwrite & (in_rd != XZR_IDX);
    assign pop_vld    = ~hold & ~fifo_empty;
    // An empty queue with retirement enabled hands the request straight to the output stage.
    assign direct_vld = ~hold & fifo_empty & keep_vld;
    assign push_vld   = keep_vld & ~direct_vld;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_vld),
        .push_dat  (in_ent),
        .pop       (pop_vld),
        .head_dat  (head_dat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_ptr  (head_ptr),
        .entries   (entries),
        .entry_vld (entry_vld)
    );

    always_comb begin
        out_vld_d = 1'b0;
        out_d     = out_q;
        if (pop_vld) begin
            out_vld_d = 1'b1;
            out_d     = head_dat;
        end else if (direct_vld) begin
            out_vld_d = 1'b1;
            out_d     = in_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
        end
    end

    assign RegWrite      = out_vld_q;
    assign WriteRegister = out_q.rd;
    assign WriteData     = out_q.data;

    // The output stage counts as pending until the edge that commits it.
    always_comb begin
        rs1_busy = wb_hit(rs1, out_vld_q, out_q);
        rs2_busy = wb_hit(rs2, out_vld_q, out_q);
        for (int i = 0; i < DEPTH; i++) begin
            rs1_busy = rs1_busy | wb_hit(rs1, entry_vld[i], entries[i]);
            rs2_busy = rs2_busy | wb_hit(rs2, entry_vld[i], entries[i]);
        end
    end

`ifdef WB_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = fifo_full;

    // Walk oldest to youngest so the last match left standing is the youngest value.
    always_comb begin
        fwd1_data = 64'h0;
        fwd2_data = 64'h0;
        if (wb_hit(rs1, out_vld_q, out_q)) fwd1_data = out_q.data;
        if (wb_hit(rs2, out_vld_q, out_q)) fwd2_data = out_q.data;
        for (int k = 0; k < DEPTH; k++) begin
            if (wb_hit(rs1, entry_vld[head_ptr + PW'(k)], entries[head_ptr + PW'(k)]))
                fwd1_data = entries[head_ptr + PW'(k)].data;
            if (wb_hit(rs2, entry_vld[head_ptr + PW'(k)], entries[head_ptr + PW'(k)]))
                fwd2_data = entries[head_ptr + PW'(k)].data;
        end
    end

    assign fwd1_valid = rs1_busy;
    assign fwd2_valid = rs2_busy;
`else
    logic unused_bypass;
    assign unused_bypass = ^{fifo_full, head_ptr, entries};

    assign fwd1_valid = 1'b0;
    assign fwd1_data  = 64'h0;
    assign fwd2_valid = 1'b0;
    assign fwd2_data  = 64'h0;
`endif

endmodule
